// File: rtl/decode_if.sv
// Bundle of the decode stage's fetch, hazard, write-back and ID/EX signals.
// The slave modport is the decode stage; the master modport is whoever
// drives it (the surrounding pipeline or a testbench).
interface decode_if;
   // fetch side
   logic [31:0] i_instr_F;
   logic [31:0] i_pc_F;
   logic [31:0] i_pc_plus4_F;
   // hazard control
   logic        i_stall_D;
   logic        i_flush_D;
   logic        i_flush_E;
   // write-back port
   logic        i_reg_write_W;
   logic [4:0]  i_rd_W;
   logic [31:0] i_result_W;
   // to hazard unit
   logic [4:0]  o_rs1_D;
   logic [4:0]  o_rs2_D;
   // ID/EX register contents
   logic        o_valid_E;
   logic        o_reg_write_E;
   logic        o_mem_write_E;
   logic        o_branch_E;
   logic        o_jump_E;
   logic        o_jalr_E;
   logic        o_alu_src_a_E;
   logic        o_alu_src_b_E;
   logic [1:0]  o_result_src_E;
   logic [3:0]  o_alu_ctrl_E;
   logic [2:0]  o_funct3_E;
   logic        o_illegal_E;
   logic [31:0] o_rd1_E;
   logic [31:0] o_rd2_E;
   logic [31:0] o_imm_ext_E;
   logic [31:0] o_pc_E;
   logic [31:0] o_pc_plus4_E;
   logic [4:0]  o_rs1_E;
   logic [4:0]  o_rs2_E;
   logic [4:0]  o_rd_E;

   modport master (
      output i_instr_F, i_pc_F, i_pc_plus4_F, i_stall_D, i_flush_D, i_flush_E,
             i_reg_write_W, i_rd_W, i_result_W,
      input  o_rs1_D, o_rs2_D, o_valid_E, o_reg_write_E, o_mem_write_E, o_branch_E,
             o_jump_E, o_jalr_E, o_alu_src_a_E, o_alu_src_b_E, o_result_src_E,
             o_alu_ctrl_E, o_funct3_E, o_illegal_E, o_rd1_E, o_rd2_E, o_imm_ext_E,
             o_pc_E, o_pc_plus4_E, o_rs1_E, o_rs2_E, o_rd_E
   );

   modport slave (
      input  i_instr_F, i_pc_F, i_pc_plus4_F, i_stall_D, i_flush_D, i_flush_E,
             i_reg_write_W, i_rd_W, i_result_W,
      output o_rs1_D, o_rs2_D, o_valid_E, o_reg_write_E, o_mem_write_E, o_branch_E,
             o_jump_E, o_jalr_E, o_alu_src_a_E, o_alu_src_b_E, o_result_src_E,
             o_alu_ctrl_E, o_funct3_E, o_illegal_E, o_rd1_E, o_rd2_E, o_imm_ext_E,
             o_pc_E, o_pc_plus4_E, o_rs1_E, o_rs2_E, o_rd_E
   );
endinterface

// File: rtl/decode.sv
// RV32I instruction-decode stage: IF/ID register, 32x32 register file with
// write-through bypass, control decoder, immediate generator and ID/EX register.
module decode #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input logic     i_clk,
   input logic     i_rst_n,
   decode_if.slave bus
);
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_SLT   = 4'b0101;
   localparam logic [3:0] ALU_SLTU  = 4'b0110;
   localparam logic [3:0] ALU_SLL   = 4'b0111;
   localparam logic [3:0] ALU_SRL   = 4'b1000;
   localparam logic [3:0] ALU_SRA   = 4'b1001;
   localparam logic [3:0] ALU_PASSB = 4'b1010;

   // IF/ID register
   logic [31:0] instr_reg;
   logic [31:0] pc_reg;
   logic [31:0] pc_plus4_reg;
   logic        valid_reg;

   // register file; entry 0 is never written so it stays at zero
   logic [31:0] rf [32];

   // instruction fields
   logic [6:0]  opcode;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic        funct7_5;

   // decoded values
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic [31:0] imm_ext;
   logic        reg_write;
   logic        mem_write;
   logic        branch;
   logic        jump;
   logic        jalr;
   logic        alu_src_a;
   logic        alu_src_b;
   logic [1:0]  result_src;
   logic [3:0]  alu_ctrl;
   logic        illegal;

   assign opcode   = instr_reg[6:0];
   assign rd       = instr_reg[11:7];
   assign funct3   = instr_reg[14:12];
   assign rs1      = instr_reg[19:15];
   assign rs2      = instr_reg[24:20];
   assign funct7_5 = instr_reg[30];

   assign bus.o_rs1_D = rs1;
   assign bus.o_rs2_D = rs2;

   // R-type and OP-IMM share the funct3 mapping; alt selects sub/sra
   function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   // IF/ID register: flush beats stall, stall holds, otherwise capture fetch
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         instr_reg    <= NOP_INSTR;
         pc_reg       <= '0;
         pc_plus4_reg <= '0;
         valid_reg    <= 1'b0;
      end else if (bus.i_flush_D) begin
         instr_reg    <= NOP_INSTR;
         pc_reg       <= '0;
         pc_plus4_reg <= '0;
         valid_reg    <= 1'b0;
      end else if (!bus.i_stall_D) begin
         instr_reg    <= bus.i_instr_F;
         pc_reg       <= bus.i_pc_F;
         pc_plus4_reg <= bus.i_pc_plus4_F;
         valid_reg    <= 1'b1;
      end
   end

   // register file write port; x0 writes are discarded
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (bus.i_reg_write_W && bus.i_rd_W != 5'd0) begin
         rf[bus.i_rd_W] <= bus.i_result_W;
      end
   end

   // read ports with write-through bypass so write-back and decode can share a cycle
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (rs1 != 5'd0)
         rd1 = (bus.i_reg_write_W && bus.i_rd_W == rs1) ? bus.i_result_W : rf[rs1];
      if (rs2 != 5'd0)
         rd2 = (bus.i_reg_write_W && bus.i_rd_W == rs2) ? bus.i_result_W : rf[rs2];
   end

   // immediate generator, format chosen by opcode
   always_comb begin
      imm_ext = '0;
      case (opcode)
         OP_LOAD, OP_IMM, OP_JALR:
            imm_ext = {{20{instr_reg[31]}}, instr_reg[31:20]};
         OP_STORE:
            imm_ext = {{20{instr_reg[31]}}, instr_reg[31:25], instr_reg[11:7]};
         OP_BRANCH:
            imm_ext = {{20{instr_reg[31]}}, instr_reg[7], instr_reg[30:25],
                       instr_reg[11:8], 1'b0};
         OP_JAL:
            imm_ext = {{12{instr_reg[31]}}, instr_reg[19:12], instr_reg[20],
                       instr_reg[30:21], 1'b0};
         OP_LUI, OP_AUIPC:
            imm_ext = {instr_reg[31:12], 12'b0};
         default:
            imm_ext = '0;
      endcase
   end

   // control decoder
   always_comb begin
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      jalr       = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 1'b0;
      result_src = 2'b00;
      alu_ctrl   = ALU_ADD;
      illegal    = 1'b0;
      case (opcode)
         OP_LOAD: begin
            reg_write  = 1'b1;
            alu_src_b  = 1'b1;
            result_src = 2'b01;
         end
         OP_STORE: begin
            mem_write = 1'b1;
            alu_src_b = 1'b1;
         end
         OP_R: begin
            reg_write = 1'b1;
            alu_ctrl  = alu_from_funct3(funct3, funct7_5);
         end
         OP_IMM: begin
            reg_write = 1'b1;
            alu_src_b = 1'b1;
            // addi has no subtract form, so funct7[5] only matters for the shift
            alu_ctrl  = alu_from_funct3(funct3, funct7_5 && funct3 == 3'b101);
         end
         OP_BRANCH: begin
            branch   = 1'b1;
            alu_ctrl = ALU_SUB;
         end
         OP_JAL: begin
            reg_write  = 1'b1;
            jump       = 1'b1;
            result_src = 2'b10;
         end
         OP_JALR: begin
            reg_write  = 1'b1;
            jump       = 1'b1;
            jalr       = 1'b1;
            alu_src_b  = 1'b1;
            result_src = 2'b10;
         end
         OP_LUI: begin
            reg_write = 1'b1;
            alu_src_b = 1'b1;
            alu_ctrl  = ALU_PASSB;
         end
         OP_AUIPC: begin
            reg_write = 1'b1;
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

   // ID/EX register: flush clears everything, bubbles never assert side-effecting bits
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n || bus.i_flush_E) begin
         bus.o_valid_E      <= 1'b0;
         bus.o_reg_write_E  <= 1'b0;
         bus.o_mem_write_E  <= 1'b0;
         bus.o_branch_E     <= 1'b0;
         bus.o_jump_E       <= 1'b0;
         bus.o_jalr_E       <= 1'b0;
         bus.o_alu_src_a_E  <= 1'b0;
         bus.o_alu_src_b_E  <= 1'b0;
         bus.o_result_src_E <= 2'b00;
         bus.o_alu_ctrl_E   <= 4'b0000;
         bus.o_funct3_E     <= 3'b000;
         bus.o_illegal_E    <= 1'b0;
         bus.o_rd1_E        <= '0;
         bus.o_rd2_E        <= '0;
         bus.o_imm_ext_E    <= '0;
         bus.o_pc_E         <= '0;
         bus.o_pc_plus4_E   <= '0;
         bus.o_rs1_E        <= '0;
         bus.o_rs2_E        <= '0;
         bus.o_rd_E         <= '0;
      end else begin
         bus.o_valid_E      <= valid_reg;
         bus.o_reg_write_E  <= reg_write & valid_reg;
         bus.o_mem_write_E  <= mem_write & valid_reg;
         bus.o_branch_E     <= branch & valid_reg;
         bus.o_jump_E       <= jump & valid_reg;
         bus.o_jalr_E       <= jalr & valid_reg;
         bus.o_alu_src_a_E  <= alu_src_a;
         bus.o_alu_src_b_E  <= alu_src_b;
         bus.o_result_src_E <= result_src;
         bus.o_alu_ctrl_E   <= alu_ctrl;
         bus.o_funct3_E     <= funct3;
         bus.o_illegal_E    <= illegal & valid_reg;
         bus.o_rd1_E        <= rd1;
         bus.o_rd2_E        <= rd2;
         bus.o_imm_ext_E    <= imm_ext;
         bus.o_pc_E         <= pc_reg;
         bus.o_pc_plus4_E   <= pc_plus4_reg;
         bus.o_rs1_E        <= rs1;
         bus.o_rs2_E        <= rs2;
         bus.o_rd_E         <= rd;
      end
   end
endmodule

// File: tb/tb_decode.sv
// Self-checking bench for the decode stage: directed steps followed by random
// traffic, compared against an instruction-level reference model.
module tb_decode;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   decode_if dif ();
   decode u_dut (.i_clk(clk), .i_rst_n(rst_n), .bus(dif));

   typedef struct packed {
      logic        v, rw, mw, br, j, jr, sa, sb, ill;
      logic [1:0]  rs;
      logic [3:0]  alu;
      logic [2:0]  f3;
      logic [31:0] rd1, rd2, imm, pc, pc4;
      logic [4:0]  rs1, rs2, rd;
   } ex_t;

   // reference state: IF/ID contents, architectural registers, expected ID/EX
   logic [31:0] m_instr, m_pc, m_pc4;
   logic        m_valid;
   logic [31:0] m_rf [32];
   ex_t         exp_e;
   bit          full;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, want);
   endtask

   function automatic logic [31:0] rf_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (dif.i_reg_write_W && dif.i_rd_W == a) return dif.i_result_W;
      return m_rf[a];
   endfunction

   // what execute should see for the instruction currently in the model's IF/ID
   function automatic ex_t ref_decode();
      ex_t e;
      logic [31:0] ins;
      logic [3:0]  tab [8];
      ins = m_instr;
      e   = '0;
      tab = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
      e.v   = m_valid;
      e.f3  = ins[14:12];
      e.rs1 = ins[19:15];
      e.rs2 = ins[24:20];
      e.rd  = ins[11:7];
      e.rd1 = rf_read(ins[19:15]);
      e.rd2 = rf_read(ins[24:20]);
      e.pc  = m_pc;
      e.pc4 = m_pc4;
      case (ins[6:0])
         7'h03: begin e.rw = 1; e.sb = 1; e.rs = 2'd1; e.imm = 32'($signed(ins) >>> 20); end
         7'h23: begin e.mw = 1; e.sb = 1;
                      e.imm = 32'(($signed(ins) >>> 25) * 32) | 32'(ins[11:7]); end
         7'h33: begin e.rw = 1; e.alu = tab[ins[14:12]];
                      if (ins[14:12] == 3'd0 && ins[30]) e.alu = 4'd1;
                      if (ins[14:12] == 3'd5 && ins[30]) e.alu = 4'd9; end
         7'h13: begin e.rw = 1; e.sb = 1; e.alu = tab[ins[14:12]];
                      if (ins[14:12] == 3'd5 && ins[30]) e.alu = 4'd9;
                      e.imm = 32'($signed(ins) >>> 20); end
         7'h63: begin e.br = 1; e.alu = 4'd1;
                      e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
         7'h6F: begin e.rw = 1; e.j = 1; e.rs = 2'd2;
                      e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; end
         7'h67: begin e.rw = 1; e.j = 1; e.jr = 1; e.sb = 1; e.rs = 2'd2;
                      e.imm = 32'($signed(ins) >>> 20); end
         7'h37: begin e.rw = 1; e.sb = 1; e.alu = 4'd10; e.imm = ins & 32'hFFFF_F000; end
         7'h17: begin e.rw = 1; e.sa = 1; e.sb = 1; e.imm = ins & 32'hFFFF_F000; end
         default: e.ill = 1;
      endcase
      if (!m_valid) begin
         e.rw = 0; e.mw = 0; e.br = 0; e.j = 0; e.jr = 0; e.ill = 0;
      end
      return e;
   endfunction

   task automatic model_reset();
      m_instr = NOP; m_pc = 0; m_pc4 = 0; m_valid = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
      exp_e = '0;
      full  = 1;
   endtask

   // model of one rising edge, using the inputs as currently driven
   task automatic model_edge();
      if (dif.i_flush_E) begin exp_e = '0; full = 1; end
      else begin exp_e = ref_decode(); full = m_valid; end
      if (dif.i_flush_D) begin
         m_instr = NOP; m_valid = 0; m_pc = 0; m_pc4 = 0;
      end else if (!dif.i_stall_D) begin
         m_instr = dif.i_instr_F; m_pc = dif.i_pc_F; m_pc4 = dif.i_pc_plus4_F; m_valid = 1;
      end
      if (dif.i_reg_write_W && dif.i_rd_W != 5'd0) m_rf[dif.i_rd_W] = dif.i_result_W;
   endtask

   task automatic check_all();
      chk("valid_E", dif.o_valid_E, exp_e.v);
      chk("reg_write_E", dif.o_reg_write_E, exp_e.rw);
      chk("mem_write_E", dif.o_mem_write_E, exp_e.mw);
      chk("branch_E", dif.o_branch_E, exp_e.br);
      chk("jump_E", dif.o_jump_E, exp_e.j);
      chk("jalr_E", dif.o_jalr_E, exp_e.jr);
      chk("illegal_E", dif.o_illegal_E, exp_e.ill);
      chk("rs1_D", dif.o_rs1_D, m_instr[19:15]);
      chk("rs2_D", dif.o_rs2_D, m_instr[24:20]);
      if (full) begin
         chk("alu_src_a_E", dif.o_alu_src_a_E, exp_e.sa);
         chk("alu_src_b_E", dif.o_alu_src_b_E, exp_e.sb);
         chk("result_src_E", dif.o_result_src_E, exp_e.rs);
         chk("alu_ctrl_E", dif.o_alu_ctrl_E, exp_e.alu);
         chk("funct3_E", dif.o_funct3_E, exp_e.f3);
         chk("rd1_E", dif.o_rd1_E, exp_e.rd1);
         chk("rd2_E", dif.o_rd2_E, exp_e.rd2);
         chk("imm_ext_E", dif.o_imm_ext_E, exp_e.imm);
         chk("pc_E", dif.o_pc_E, exp_e.pc);
         chk("pc_plus4_E", dif.o_pc_plus4_E, exp_e.pc4);
         chk("rs1_E", dif.o_rs1_E, exp_e.rs1);
         chk("rs2_E", dif.o_rs2_E, exp_e.rs2);
         chk("rd_E", dif.o_rd_E, exp_e.rd);
      end
   endtask

   task automatic set_in(input logic [31:0] instr, input logic [31:0] pc,
                         input logic stall, input logic flush_d, input logic flush_e,
                         input logic we, input logic [4:0] rd_w, input logic [31:0] res);
      dif.i_instr_F     = instr;
      dif.i_pc_F        = pc;
      dif.i_pc_plus4_F  = pc + 32'd4;
      dif.i_stall_D     = stall;
      dif.i_flush_D     = flush_d;
      dif.i_flush_E     = flush_e;
      dif.i_reg_write_W = we;
      dif.i_rd_W        = rd_w;
      dif.i_result_W    = res;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops [9];
      logic [6:0] op;
      int k;
      ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      k = $urandom_range(0, 9);
      if (k < 9) op = ops[k];
      else begin
         op = 7'h7F;
         for (int t = 0; t < 16; t++) begin
            op = 7'($urandom);
            if (!(op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17}))
               break;
            op = 7'h7F;
         end
      end
      return {25'($urandom), op};
   endfunction

   task automatic random_steps(input int n, input logic [31:0] pc0);
      logic [31:0] pc;
      pc = pc0;
      for (int s = 0; s < n; s++) begin
         set_in(rand_instr(), pc,
                $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                5'($urandom), $urandom);
         pc = pc + 32'd4;
         step();
      end
   endtask

   initial begin
      set_in(32'd0, 32'd0, 0, 0, 0, 0, 5'd0, 32'd0);
      model_reset();
      #12;
      check_all();                                   // reset state
      @(negedge clk) rst_n = 1'b1;

      set_in(32'd0, 32'd0, 0, 0, 0, 0, 5'd0, 32'd0);
      step();                                        // bubble from reset reaches execute
      chk("first_valid", dif.o_valid_E, 1'b0);

      set_in(32'h0052_8333, 32'h4, 0, 0, 0, 0, 5'd0, 32'd0);   // add x6,x5,x5
      step();
      set_in(NOP, 32'h8, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);     // write x5 while decoding
      step();
      chk("bypass_rd1", dif.o_rd1_E, 32'hDEAD_BEEF);
      chk("bypass_rd2", dif.o_rd2_E, 32'hDEAD_BEEF);
      chk("add_alu", dif.o_alu_ctrl_E, 4'b0000);
      chk("add_rd", dif.o_rd_E, 5'd6);

      set_in(32'h0000_03B3, 32'hC, 0, 0, 0, 1, 5'd0, 32'h1234); // add x7,x0,x0 ; write x0
      step();
      set_in(NOP, 32'h10, 0, 0, 0, 0, 5'd0, 32'd0);
      step();
      chk("x0_reads_zero", dif.o_rd1_E, 32'd0);

      set_in(32'hFE00_0EE3, 32'h14, 0, 0, 0, 0, 5'd0, 32'd0);  // beq x0,x0,-4
      step();
      set_in(32'hABCD_E0B7, 32'h18, 0, 0, 0, 0, 5'd0, 32'd0);  // lui x1,0xABCDE
      step();
      chk("beq_imm", dif.o_imm_ext_E, 32'hFFFF_FFFC);
      chk("beq_branch", dif.o_branch_E, 1'b1);
      chk("beq_alu", dif.o_alu_ctrl_E, 4'b0001);
      set_in(NOP, 32'h1C, 0, 0, 0, 0, 5'd0, 32'd0);
      step();
      chk("lui_imm", dif.o_imm_ext_E, 32'hABCD_E000);

      set_in(32'h0050_0093, 32'h10, 0, 0, 0, 0, 5'd0, 32'd0);  // IF/ID gets pc 0x10
      step();
      set_in(32'h0050_0093, 32'h14, 1, 0, 0, 0, 5'd0, 32'd0);
      step();
      chk("stall1_pc", dif.o_pc_E, 32'h10);
      set_in(32'h0050_0093, 32'h18, 1, 0, 0, 0, 5'd0, 32'd0);
      step();
      chk("stall2_pc", dif.o_pc_E, 32'h10);
      set_in(32'h0050_0093, 32'h1C, 0, 0, 0, 0, 5'd0, 32'd0);
      step();
      chk("stall_release_pc", dif.o_pc_E, 32'h10);

      set_in(32'h00A0_0113, 32'h40, 0, 0, 0, 0, 5'd0, 32'd0);  // addi x2,x0,10
      step();
      set_in(32'h0000_0000, 32'h44, 1, 0, 1, 0, 5'd0, 32'd0);  // load-use: stall + flush_E
      step();
      chk("loaduse_bubble", dif.o_valid_E, 1'b0);
      set_in(32'h0000_0000, 32'h44, 0, 0, 0, 0, 5'd0, 32'd0);
      step();
      chk("loaduse_issue_valid", dif.o_valid_E, 1'b1);
      chk("loaduse_issue_pc", dif.o_pc_E, 32'h40);

      set_in(32'h0050_0093, 32'h50, 1, 1, 0, 0, 5'd0, 32'd0);  // flush_D beats stall
      step();
      set_in(NOP, 32'h54, 0, 0, 0, 0, 5'd0, 32'd0);
      step();
      chk("flushd_bubble", dif.o_valid_E, 1'b0);

      set_in(32'h0000_007F, 32'h60, 0, 0, 0, 0, 5'd0, 32'd0);  // opcode 1111111
      step();
      set_in(NOP, 32'h64, 0, 0, 0, 0, 5'd0, 32'd0);
      step();
      chk("illegal_flag", dif.o_illegal_E, 1'b1);
      chk("illegal_regw", dif.o_reg_write_E, 1'b0);
      chk("illegal_srcb", dif.o_alu_src_b_E, 1'b0);

      random_steps(300, 32'h100);

      // asynchronous reset in the middle of a cycle
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("midreset_pc", dif.o_pc_E, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      random_steps(150, 32'h800);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
